lcd_debug_scheduler: RTL and testbench
======================================

LCD_DEBUG_SCHEDULER -- requirements
Module: lcd_debug_scheduler

Interface
REQ-001 Parameter REFRESH_CYCLES, default 2500000, clk_in cycles between refresh ticks (20 Hz at 50 MHz).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk_in  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 debug_reg1..debug_reg4  in  32 each  debug words to display.
REQ-006 page_next  in  1  single-cycle pulse, pre-debounced; advances display page.
REQ-007 lcd_ready  in  1  downstream LCD driver can accept a byte.
REQ-008 lcd_valid  out  1  byte offered to LCD driver.
REQ-009 lcd_rs  out  1  0 = command byte, 1 = character byte.
REQ-010 lcd_data  out  8  command or ASCII byte.
REQ-011 busy  out  1  high whenever FSM is not IDLE.
REQ-012 frame_done  out  1  one-cycle pulse when last byte of a frame transfers.
REQ-013 page  out  1  page used by the current or most recent frame.
REQ-014 overrun  out  1  sticky; a refresh tick was lost.

Function
REQ-015 Refresh counter SHALL run freely 0..REFRESH_CYCLES-1 and wrap; a tick SHALL occur in the cycle the counter equals REFRESH_CYCLES-1.
REQ-016 FSM states SHALL be IDLE, SNAP, ADDR1, LINE1, ADDR2, LINE2; a byte transfers only in a cycle with lcd_valid=1 and lcd_ready=1.
REQ-017 IDLE -> SNAP on a tick or a set pending flag; SNAP lasts exactly one cycle; lcd_valid SHALL rise in the cycle after SNAP.
REQ-018 SNAP SHALL latch page_req into page and latch the two displayed registers: page 0 = debug_reg1/debug_reg2, page 1 = debug_reg3/debug_reg4; the frame uses only latched values.
REQ-019 ADDR1 sends 0x80 with rs=0; ADDR2 sends 0xC0 with rs=0; each advances on transfer.
REQ-020 LINE1/LINE2 each send 16 bytes with rs=1: 'R', ASCII index digit ('1'..'4'), '=', 8 hex digits MSB nibble first, then 5 x 0x20.
REQ-021 Hex nibble 0-9 maps to 0x30-0x39 and A-F to 0x41-0x46 (uppercase).
REQ-022 A 5-bit character index SHALL count 0..15 per line and reset on line entry.
REQ-023 While lcd_valid=1 and lcd_ready=0, lcd_rs and lcd_data SHALL hold stable; lcd_valid SHALL not drop until transfer.
REQ-024 Valid SHALL stay high back-to-back between bytes; at lcd_ready=1 continuously a frame is 34 consecutive transfers.
REQ-025 The transfer of LINE2 byte 15 SHALL pulse frame_done in that cycle and return FSM to IDLE next cycle.
REQ-026 A tick while not IDLE SHALL set pending; a tick while pending is already set SHALL set overrun; pending clears on entering SNAP.
REQ-027 page_next SHALL toggle page_req (1 wraps to 0) in any state; the change appears at the next SNAP only.
REQ-028 Tick and frame_done in the same cycle SHALL set pending, so the next frame starts without loss.

Reset
REQ-029 On reset, immediately: lcd_valid=0, lcd_rs=0, lcd_data=0x00, busy=0, frame_done=0, page=0, page_req=0, overrun=0, pending=0, counter=0, FSM=IDLE.
REQ-030 Reset mid-frame SHALL abort without completing any handshake; first tick after release occurs REFRESH_CYCLES cycles later.

Verification (REFRESH_CYCLES=100)
REQ-031 lcd_ready=1, debug_reg1=0xDEADBEEF, debug_reg2=0x000000A5 -> 34 transfers: 0x80, "R1=DEADBEEF     ", 0xC0, "R2=000000A5     "; frame_done pulses once on the last.
REQ-032 lcd_ready low 10 cycles on LINE1 byte 5 -> lcd_data held at 'D' (0x44), no byte dropped or duplicated.
REQ-033 page_next pulse during frame 1 -> frame 1 shows R1/R2, frame 2 shows R3/R4, page=1.
REQ-034 lcd_ready=0 for 250 cycles mid-frame -> overrun=1, pending frame starts (SNAP) the cycle after frame_done.
REQ-035 Reset asserted after 5th transfer -> lcd_valid=0 asynchronously; after release, next byte is 0x80 on the 100-cycle tick.
REQ-036 debug_reg1 changed to 0x12345678 during LINE1 -> frame still shows DEADBEEF; next frame shows 12345678.

Source files
------------

// File: rtl/lcd_debug_scheduler.sv
// lcd_debug_scheduler: periodically streams two 32-bit debug words as hex text to a 2-line LCD byte driver
module lcd_debug_scheduler #(
  parameter int REFRESH_CYCLES = 2500000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] debug_reg1,
  input  logic [31:0] debug_reg2,
  input  logic [31:0] debug_reg3,
  input  logic [31:0] debug_reg4,
  input  logic        page_next,
  input  logic        lcd_ready,
  output logic        lcd_valid,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        frame_done,
  output logic        page,
  output logic        overrun
);
  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SNAP, ADDR1, LINE1, ADDR2, LINE2} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] count;
  logic tick, pending, page_req, xfer, line_end;
  logic [4:0] idx;
  logic [31:0] word1, word2, word;
  logic [3:0] nib;
  logic [7:0] hex, chr;
  assign tick = count == LAST;
  assign xfer = lcd_valid && lcd_ready;
  assign line_end = idx == 5'd15;
  // Free-running refresh counter; tick on its terminal value
  always_ff @(posedge clk_in or posedge reset)
    if (reset) count <= '0;
    else count <= tick ? '0 : count + 1'b1;
  // State register
  always_ff @(posedge clk_in or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // Frame bookkeeping: pending/overrun tracking, page selection, snapshot and character index
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      pending  <= 1'b0;
      overrun  <= 1'b0;
      page_req <= 1'b0;
      page     <= 1'b0;
      word1    <= '0;
      word2    <= '0;
      idx      <= '0;
    end else begin
      page_req <= page_req ^ page_next;
      if (state == IDLE) pending <= 1'b0;
      else if (tick) begin
        pending <= 1'b1;
        if (pending) overrun <= 1'b1;
      end
      if (state == SNAP) begin
        page  <= page_req;
        word1 <= page_req ? debug_reg3 : debug_reg1;
        word2 <= page_req ? debug_reg4 : debug_reg2;
      end
      if (state == ADDR1 || state == ADDR2) idx <= '0;
      else if (xfer) idx <= idx + 1'b1;
    end
  // Next-state logic: a frame is SNAP, address, 16 chars, address, 16 chars
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (tick || pending) ? SNAP : IDLE;
      SNAP:    state_nxt = ADDR1;
      ADDR1:   state_nxt = xfer ? LINE1 : ADDR1;
      LINE1:   state_nxt = (xfer && line_end) ? ADDR2 : LINE1;
      ADDR2:   state_nxt = xfer ? LINE2 : ADDR2;
      LINE2:   state_nxt = (xfer && line_end) ? IDLE : LINE2;
      default: state_nxt = IDLE;
    endcase
  end
  // Byte generation from state and index; depends only on registered values so it holds while stalled
  always_comb begin
    word       = (state == LINE2) ? word2 : word1;
    nib        = 4'(word >> (7'd40 - {idx, 2'b00}));
    hex        = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    chr        = (idx == 5'd0) ? 8'h52 :
                 (idx == 5'd1) ? 8'h31 + {6'd0, page, state == LINE2} :
                 (idx == 5'd2) ? 8'h3D :
                 (idx <= 5'd10) ? hex : 8'h20;
    lcd_valid  = state != IDLE && state != SNAP;
    lcd_rs     = state == LINE1 || state == LINE2;
    lcd_data   = (state == ADDR1) ? 8'h80 : (state == ADDR2) ? 8'hC0 : lcd_rs ? chr : 8'h00;
    busy       = state != IDLE;
    frame_done = state == LINE2 && line_end && xfer;
  end
endmodule

// File: tb/tb_lcd_debug_scheduler.sv
// tb_lcd_debug_scheduler: scoreboard bench for lcd_debug_scheduler with directed frames
module tb_lcd_debug_scheduler;
  localparam int RC = 100;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic [31:0] r1, r2, r3, r4;
  logic page_next = 1'b0;
  logic lcd_ready = 1'b0;
  logic lcd_valid, lcd_rs, busy, frame_done, page, overrun;
  logic [7:0] lcd_data;
  int checks = 0;
  int fails = 0;
  int xfers = 0;
  logic [9:0] exp_q[$];
  string hx = "0123456789ABCDEF";

  lcd_debug_scheduler #(.REFRESH_CYCLES(RC)) dut (
    .clk_in(clk_in), .reset(reset),
    .debug_reg1(r1), .debug_reg2(r2), .debug_reg3(r3), .debug_reg4(r4),
    .page_next(page_next), .lcd_ready(lcd_ready),
    .lcd_valid(lcd_valid), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
    .busy(busy), .frame_done(frame_done), .page(page), .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [7:0] digit, input logic [31:0] w, input bit last);
    logic [7:0] s [16];
    s[0] = 8'h52;
    s[1] = digit;
    s[2] = 8'h3D;
    for (int k = 0; k < 8; k++) s[3+k] = hx[int'(4'(w >> (28 - 4*k)))];
    for (int k = 11; k < 16; k++) s[k] = 8'h20;
    for (int k = 0; k < 16; k++) exp_q.push_back({last && k == 15, 1'b1, s[k]});
  endtask

  task automatic push_frame(input bit pg, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back({2'b00, 8'h80});
    push_line(pg ? 8'h33 : 8'h31, a, 1'b0);
    exp_q.push_back({2'b00, 8'hC0});
    push_line(pg ? 8'h34 : 8'h32, b, 1'b1);
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_in);
      if (xfers >= target) return;
    end
    checks++;
    fails++;
    $display("FAIL %s timeout: transfers %0d expected %0d", name, xfers, target);
  endtask

  task automatic pulse_page;
    page_next = 1'b1;
    @(posedge clk_in);
    #1 page_next = 1'b0;
  endtask

  always @(negedge clk_in) begin
    logic [9:0] e;
    if (!reset && lcd_valid && lcd_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_byte: got rs=%b data=%h expected none", lcd_rs, lcd_data);
      end else begin
        e = exp_q.pop_front();
        chk("byte", {23'd0, lcd_rs, lcd_data}, {23'd0, e[8:0]});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e[9]});
      end
    end
  end

  initial begin
    int n;
    r1 = 32'hDEADBEEF;
    r2 = 32'h000000A5;
    r3 = 32'hCAFE0123;
    r4 = 32'h00FF7E10;
    lcd_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_valid", {31'd0, lcd_valid}, 0);
    chk("rst_rs", {31'd0, lcd_rs}, 0);
    chk("rst_data", {24'd0, lcd_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_page", {31'd0, page}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    reset = 1'b0;
    push_frame(1'b0, 32'hDEADBEEF, 32'h000000A5);
    wait_xfers(34, 300, "frame1");
    #1;
    chk("idle_after_frame1", {31'd0, busy}, 0);
    chk("queue_empty_frame1", exp_q.size(), 0);
    push_frame(1'b0, 32'hDEADBEEF, 32'h000000A5);
    wait_xfers(41, 200, "stall_start");
    #1 lcd_ready = 1'b0;
    r1 = 32'h12345678;
    pulse_page();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      chk("stall_valid", {31'd0, lcd_valid}, 1);
      chk("stall_data", {24'd0, lcd_data}, 32'h44);
      chk("stall_rs", {31'd0, lcd_rs}, 1);
    end
    @(posedge clk_in);
    #1 lcd_ready = 1'b1;
    wait_xfers(68, 100, "frame2");
    #1 chk("page_frame2", {31'd0, page}, 0);
    push_frame(1'b1, 32'hCAFE0123, 32'h00FF7E10);
    wait_xfers(69, 200, "frame3_start");
    #1 chk("page_frame3", {31'd0, page}, 1);
    wait_xfers(82, 100, "frame3_mid");
    #1 pulse_page();
    wait_xfers(102, 100, "frame3");
    #1;
    chk("page_after_frame3", {31'd0, page}, 1);
    chk("no_overrun_yet", {31'd0, overrun}, 0);
    push_frame(1'b0, 32'h12345678, 32'h000000A5);
    push_frame(1'b0, 32'h12345678, 32'h000000A5);
    wait_xfers(112, 200, "frame4_mid");
    #1 chk("page_frame4", {31'd0, page}, 0);
    lcd_ready = 1'b0;
    repeat (250) @(posedge clk_in);
    #1;
    chk("overrun_set", {31'd0, overrun}, 1);
    chk("valid_held_long", {31'd0, lcd_valid}, 1);
    lcd_ready = 1'b1;
    wait_xfers(136, 200, "frame4");
    #1 chk("idle_after_done", {31'd0, busy}, 0);
    @(posedge clk_in);
    #1 chk("pending_snap", {31'd0, busy}, 1);
    wait_xfers(141, 50, "frame5_mid");
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, lcd_valid}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_overrun", {31'd0, overrun}, 0);
    chk("async_rst_page", {31'd0, page}, 0);
    exp_q.delete();
    push_frame(1'b0, 32'h12345678, 32'h000000A5);
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    n = 0;
    while (!lcd_valid && n < 300) begin
      @(posedge clk_in);
      n++;
      #1;
    end
    chk("first_valid_cycles", n, 101);
    chk("first_byte_after_rst", {23'd0, lcd_rs, lcd_data}, 32'h080);
    wait_xfers(175, 100, "frame6");
    #1 chk("queue_empty_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
